// File: rtl/icu_core_v2_if.sv
// Program-load bus of the icu_core_v2: write strobe, address and instruction word.
// The loader drives the master side; the core only samples it while halted.
interface icu_core_v2_if #(
  parameter int ADDR = 8,
  parameter int CODE = 4
);
  localparam int WORD = ADDR + CODE;

  logic            program_write;
  logic [ADDR-1:0] program_addr;
  logic [WORD-1:0] program_cmd;

  modport master (output program_write, program_addr, program_cmd);
  modport slave  (input  program_write, program_addr, program_cmd);
endinterface

// File: rtl/icu_core_v2.sv
// MC14500B-style 1-bit control core with program store, bit data space,
// IEN/OEN gating, SKZ skip and a bounded hardware call/return stack.
module icu_core_v2 #(
  parameter int ADDR        = 8,
  parameter int CODE        = 4,
  parameter int WORD        = ADDR + CODE,
  parameter int INPUT       = 5,
  parameter int OUTPUT      = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  icu_core_v2_if.slave      prog,
  input  logic [INPUT-1:0]  input_pins,
  output logic [OUTPUT-1:0] output_pins,
  output logic [ADDR-1:0]   pc,
  output logic              rr,
  output logic              flag_o,
  output logic              flag_f,
  output logic              stack_err
);
  localparam int DSIZE = 2 ** ADDR;
  localparam int SPW   = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  localparam logic [CODE-1:0] OP_NOPO = CODE'(4'h0);
  localparam logic [CODE-1:0] OP_LD   = CODE'(4'h1);
  localparam logic [CODE-1:0] OP_LDC  = CODE'(4'h2);
  localparam logic [CODE-1:0] OP_AND  = CODE'(4'h3);
  localparam logic [CODE-1:0] OP_ANDC = CODE'(4'h4);
  localparam logic [CODE-1:0] OP_OR   = CODE'(4'h5);
  localparam logic [CODE-1:0] OP_ORC  = CODE'(4'h6);
  localparam logic [CODE-1:0] OP_XNOR = CODE'(4'h7);
  localparam logic [CODE-1:0] OP_STO  = CODE'(4'h8);
  localparam logic [CODE-1:0] OP_STOC = CODE'(4'h9);
  localparam logic [CODE-1:0] OP_IEN  = CODE'(4'hA);
  localparam logic [CODE-1:0] OP_OEN  = CODE'(4'hB);
  localparam logic [CODE-1:0] OP_JMP  = CODE'(4'hC);
  localparam logic [CODE-1:0] OP_RTN  = CODE'(4'hD);
  localparam logic [CODE-1:0] OP_SKZ  = CODE'(4'hE);
  localparam logic [CODE-1:0] OP_NOPF = CODE'(4'hF);

  logic [WORD-1:0]   mem_q [DSIZE];
  logic [ADDR-1:0]   pc_q, pc_d, pc_inc;
  logic              rr_q, rr_d, ien_q, ien_d, oen_q, oen_d, skip_q, skip_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic [ADDR-1:0]   stack_q [STACK_DEPTH];
  logic [ADDR-1:0]   stack_d [STACK_DEPTH];
  logic [OUTPUT-1:0] out_q, out_d;
  logic [DSIZE-1:0]  scratch_q, scratch_d;
  logic [INPUT-1:0]  sync1_q, sync2_q;
  logic              flag_o_q, flag_o_d, flag_f_q, flag_f_d, err_q, err_d;

  logic [WORD-1:0]   instr;
  logic [CODE-1:0]   opcode;
  logic [ADDR-1:0]   oper;
  logic [ADDR-1:0]   pop_val;
  logic              raw, d, store_en, store_val;

  // Program store has no reset so a loaded program survives a reset pulse.
  always_ff @(posedge clk) begin
    if (!run && prog.program_write) mem_q[prog.program_addr] <= prog.program_cmd;
  end

  assign instr  = mem_q[pc_q];
  assign opcode = instr[WORD-1:ADDR];
  assign oper   = instr[ADDR-1:0];
  assign pc_inc = pc_q + ADDR'(1);

  always_comb begin
    raw = scratch_q[oper];
    for (int i = 0; i < INPUT; i++)
      if (oper == ADDR'(i)) raw = sync2_q[i];
    for (int i = 0; i < OUTPUT; i++)
      if (oper == ADDR'(INPUT + i)) raw = out_q[i];
    if (oper == '1) raw = rr_q;
    d = raw & ien_q;
  end

  always_comb begin
    pop_val = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (sp_q == SPW'(i + 1)) pop_val = stack_q[i];
  end

  always_comb begin
    pc_d      = pc_q;
    rr_d      = rr_q;
    ien_d     = ien_q;
    oen_d     = oen_q;
    skip_d    = skip_q;
    sp_d      = sp_q;
    stack_d   = stack_q;
    out_d     = out_q;
    scratch_d = scratch_q;
    err_d     = err_q;
    flag_o_d  = 1'b0;
    flag_f_d  = 1'b0;
    store_en  = 1'b0;
    store_val = 1'b0;
    if (!run) begin
      pc_d   = '0;
      skip_d = 1'b0;
    end else if (skip_q) begin
      pc_d   = pc_inc;
      skip_d = 1'b0;
    end else begin
      pc_d = pc_inc;
      case (opcode)
        OP_NOPO: flag_o_d = 1'b1;
        OP_LD:   rr_d = d;
        OP_LDC:  rr_d = ~d;
        OP_AND:  rr_d = rr_q & d;
        OP_ANDC: rr_d = rr_q & ~d;
        OP_OR:   rr_d = rr_q | d;
        OP_ORC:  rr_d = rr_q | ~d;
        OP_XNOR: rr_d = ~(rr_q ^ d);
        OP_STO:  begin store_en = oen_q; store_val = rr_q;  end
        OP_STOC: begin store_en = oen_q; store_val = ~rr_q; end
        OP_IEN:  ien_d = raw;
        OP_OEN:  oen_d = raw;
        OP_JMP: begin
          pc_d = oper;
          // A full stack still takes the jump; only the return address is lost.
          if (sp_q == SP_FULL) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < STACK_DEPTH; i++)
              if (sp_q == SPW'(i)) stack_d[i] = pc_inc;
            sp_d = sp_q + SPW'(1);
          end
        end
        OP_RTN: begin
          if (sp_q == '0) begin
            err_d = 1'b1;
          end else begin
            pc_d = pop_val;
            sp_d = sp_q - SPW'(1);
          end
        end
        OP_SKZ:  if (!rr_q) skip_d = 1'b1;
        OP_NOPF: flag_f_d = 1'b1;
        default: ;
      endcase
    end
    if (store_en) begin
      for (int i = 0; i < OUTPUT; i++)
        if (oper == ADDR'(INPUT + i)) out_d[i] = store_val;
      if (oper >= ADDR'(INPUT + OUTPUT) && oper != '1) scratch_d[oper] = store_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      rr_q      <= 1'b0;
      ien_q     <= 1'b1;
      oen_q     <= 1'b1;
      skip_q    <= 1'b0;
      sp_q      <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      out_q     <= '0;
      scratch_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      flag_o_q  <= 1'b0;
      flag_f_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      rr_q      <= rr_d;
      ien_q     <= ien_d;
      oen_q     <= oen_d;
      skip_q    <= skip_d;
      sp_q      <= sp_d;
      stack_q   <= stack_d;
      out_q     <= out_d;
      scratch_q <= scratch_d;
      sync1_q   <= input_pins;
      sync2_q   <= sync1_q;
      flag_o_q  <= flag_o_d;
      flag_f_q  <= flag_f_d;
      err_q     <= err_d;
    end
  end

  assign output_pins = out_q;
  assign pc          = pc_q;
  assign rr          = rr_q;
  assign flag_o      = flag_o_q;
  assign flag_f      = flag_f_q;
  assign stack_err   = err_q;
endmodule
